// File: rtl/sop_sweep_ctrl.sv
// sop_sweep_ctrl: steps a 3-input SoP unit through all 8 minterms and captures its truth table.
// Define SOP_SWEEP_COMPARE_EN to compile in the expect latch and compare stage.
module sop_sweep_ctrl #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] expect_table,
    input  logic       s,
    output logic       x,
    output logic       y,
    output logic       z,
    output logic       busy,
    output logic       done,
    output logic [7:0] truth_table,
    output logic [7:0] mismatch,
    output logic       pass
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] tbl_q, tbl_d;
    logic       done_q, done_d;
`ifdef SOP_SWEEP_COMPARE_EN
    logic [7:0] exp_q, exp_d, mis_q, mis_d;
    logic       pass_q, pass_d;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tbl_d   = tbl_q;
        done_d  = 1'b0;
`ifdef SOP_SWEEP_COMPARE_EN
        exp_d   = exp_q;
        mis_d   = mis_q;
        pass_d  = pass_q;
`endif
        if (state_q == IDLE) begin
            if (start) begin
                state_d = RUN;
                idx_d   = 3'd0;
                cnt_d   = RELOAD;
                tbl_d   = 8'h00;
`ifdef SOP_SWEEP_COMPARE_EN
                exp_d   = expect_table;
                mis_d   = 8'h00;
                pass_d  = 1'b0;
`endif
            end
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end else begin
            tbl_d[idx_q] = s;
            if (idx_q == 3'd7) begin
                // compare uses tbl_d so the bit sampled at this edge is included
                state_d = IDLE;
                idx_d   = 3'd0;
                done_d  = 1'b1;
`ifdef SOP_SWEEP_COMPARE_EN
                mis_d   = tbl_d ^ exp_q;
                pass_d  = (tbl_d ^ exp_q) == 8'h00;
`endif
            end else begin
                idx_d = idx_q + 3'd1;
                cnt_d = RELOAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= 4'd0;
            tbl_q   <= 8'h00;
            done_q  <= 1'b0;
`ifdef SOP_SWEEP_COMPARE_EN
            exp_q   <= 8'h00;
            mis_q   <= 8'h00;
            pass_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tbl_q   <= tbl_d;
            done_q  <= done_d;
`ifdef SOP_SWEEP_COMPARE_EN
            exp_q   <= exp_d;
            mis_q   <= mis_d;
            pass_q  <= pass_d;
`endif
        end
    end

    assign {x, y, z}   = idx_q;
    assign busy        = state_q == RUN;
    assign done        = done_q;
    assign truth_table = tbl_q;
`ifdef SOP_SWEEP_COMPARE_EN
    assign mismatch    = mis_q;
    assign pass        = pass_q;
`else
    logic unused_expect;
    assign unused_expect = ^expect_table;
    assign mismatch      = 8'h00;
    assign pass          = 1'b0;
`endif
endmodule

// File: tb/tb_sop_sweep_ctrl.sv
// tb_sop_sweep_ctrl: directed checks of the sweep sequencer with SETTLE=1 and SETTLE=3 instances.
module tb_sop_sweep_ctrl;
`ifdef SOP_SWEEP_COMPARE_EN
    localparam bit CMP = 1'b1;
`else
    localparam bit CMP = 1'b0;
`endif
    localparam logic [7:0] SOP_TT = 8'hC6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n1, start1, s1, x1, y1, z1, busy1, done1, pass1;
    logic [7:0] exp1, tbl1, mis1;
    logic       rst_n3, start3, s3, x3, y3, z3, busy3, done3, pass3;
    logic [7:0] exp3, tbl3, mis3;
    logic [7:0] tt;

    assign tt = SOP_TT;
    assign s1 = tt[{x1, y1, z1}];
    assign s3 = tt[{x3, y3, z3}];

    sop_sweep_ctrl #(.SETTLE(1)) u1 (
        .clk(clk), .rst_n(rst_n1), .start(start1), .expect_table(exp1), .s(s1),
        .x(x1), .y(y1), .z(z1), .busy(busy1), .done(done1),
        .truth_table(tbl1), .mismatch(mis1), .pass(pass1)
    );
    sop_sweep_ctrl #(.SETTLE(3)) u3 (
        .clk(clk), .rst_n(rst_n3), .start(start3), .expect_table(exp3), .s(s3),
        .x(x3), .y(y3), .z(z3), .busy(busy3), .done(done3),
        .truth_table(tbl3), .mismatch(mis3), .pass(pass3)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one SETTLE=1 sweep; poke selects a cycle in which start is pulsed while busy
    task automatic sweep1(input logic [7:0] e, input int poke);
        logic [7:0] emis;
        emis = CMP ? (e ^ SOP_TT) : 8'h00;
        exp1 = e;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("s1_cleared", tbl1, 8'h00);
        for (int i = 0; i < 8; i++) begin
            check("s1_xyz", {x1, y1, z1}, i);
            check("s1_busy", busy1, 1);
            check("s1_nodone", done1, 0);
            if (i == poke) start1 = 1'b1;
            tick();
            start1 = 1'b0;
        end
        check("s1_done", done1, 1);
        check("s1_idle", busy1, 0);
        check("s1_table", tbl1, SOP_TT);
        check("s1_mismatch", mis1, emis);
        check("s1_pass", pass1, CMP && (e == SOP_TT));
        check("s1_xyz_home", {x1, y1, z1}, 0);
        tick();
        check("s1_done_fall", done1, 0);
        check("s1_table_hold", tbl1, SOP_TT);
        check("s1_mismatch_hold", mis1, emis);
    endtask

    initial begin
        int n;
        rst_n1 = 1'b0; rst_n3 = 1'b0; start1 = 1'b0; start3 = 1'b0;
        exp1 = 8'h00; exp3 = 8'h00;
        tick();
        tick();
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_table", tbl1, 8'h00);
        check("rst_xyz", {x1, y1, z1}, 0);
        check("rst_mismatch", mis1, 8'h00);
        check("rst_pass", pass1, 0);
        check("rst3_busy", busy3, 0);
        rst_n1 = 1'b1; rst_n3 = 1'b1;
        tick();

        sweep1(8'hC6, -1);
        sweep1(8'hC7, 3);
        sweep1(8'h00, 0);

        // reset asserted at the 4th RUN edge abandons the sweep
        exp1 = 8'hC6;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (3) tick();
        rst_n1 = 1'b0;
        tick();
        rst_n1 = 1'b1;
        check("mid_rst_busy", busy1, 0);
        check("mid_rst_table", tbl1, 8'h00);
        check("mid_rst_xyz", {x1, y1, z1}, 0);
        check("mid_rst_done", done1, 0);
        n = 0;
        repeat (10) begin
            tick();
            n += done1;
        end
        check("mid_rst_no_done", n, 0);
        sweep1(8'hC6, -1);

        // start held high: done every 9 cycles
        start1 = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            n = 0;
            while (!done1 && n < 20) begin
                tick();
                n++;
            end
            check("held_period", n, 8);
            check("held_table", tbl1, SOP_TT);
            tick();
            check("held_restart_busy", busy1, 1);
            check("held_restart_clear", tbl1, 8'h00);
            check("held_restart_done", done1, 0);
        end
        start1 = 1'b0;
        n = 0;
        while (busy1 && n < 20) begin
            tick();
            n++;
        end
        tick();

        // SETTLE=3
        exp3 = 8'hC6;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int i = 0; i < 24; i++) begin
            check("s3_xyz", {x3, y3, z3}, i / 3);
            check("s3_busy", busy3, 1);
            check("s3_nodone", done3, 0);
            tick();
        end
        check("s3_done", done3, 1);
        check("s3_idle", busy3, 0);
        check("s3_table", tbl3, SOP_TT);
        check("s3_pass", pass3, CMP);
        check("s3_mismatch", mis3, 8'h00);
        tick();
        check("s3_done_fall", done3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
